// File: rtl/snake_dir_input_if.sv
// Button/direction bundle between the board inputs,
// the direction stage and the game logic.
interface snake_dir_input_if;
    logic       btnu;
    logic       btnd;
    logic       btnl;
    logic       btnr;
    logic       move_tick;
    logic [1:0] direction;
    logic [1:0] next_direction;
    logic [3:0] btn_state;
    logic       press_accepted;

    modport master (
        output btnu, btnd, btnl, btnr, move_tick,
        input  direction, next_direction,
        input  btn_state, press_accepted
    );

    modport slave (
        input  btnu, btnd, btnl, btnr, move_tick,
        output direction, next_direction,
        output btn_state, press_accepted
    );
endinterface

// File: rtl/snake_dir_input.sv
// Snake button conditioning: sync, debounce, press
// arbitration, reversal guard and tick-aligned commit.
module snake_dir_input #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic              clk,
    input  logic              rst,
    snake_dir_input_if.slave  bus
);

    localparam logic [CNT_W-1:0] LP_LAST =
        CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] LP_LEFT  = 2'd0;
    localparam logic [1:0] LP_RIGHT = 2'd1;
    localparam logic [1:0] LP_UP    = 2'd2;
    localparam logic [1:0] LP_DOWN  = 2'd3;

    // bit order {u,d,l,r}
    logic [3:0]       w_raw;
    logic [3:0]       r_sync1;
    logic [3:0]       r_sync2;
    logic [3:0]       r_stable;
    logic [3:0]       r_stable_d;
    logic [CNT_W-1:0] r_cnt [4];
    logic [1:0]       r_dir;
    logic [1:0]       r_next;
    logic             r_pa;

    logic [3:0]       w_rise;
    logic             w_cand_vld;
    logic [1:0]       w_cand;
    logic [1:0]       w_ref;
    logic             w_accept;

    assign w_raw = {bus.btnu, bus.btnd, bus.btnl, bus.btnr};

    // two-flop synchroniser for the asynchronous buttons
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    // per-button debounce: a new level must persist a full count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stable <= '0;
            for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == LP_LAST) begin
                    r_stable[i] <= r_sync2[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_rise = r_stable & ~r_stable_d;

    // simultaneous presses: right > left > up > down, losers dropped
    always_comb begin
        w_cand_vld = 1'b1;
        w_cand     = LP_RIGHT;
        if (w_rise[0])      w_cand = LP_RIGHT;
        else if (w_rise[1]) w_cand = LP_LEFT;
        else if (w_rise[3]) w_cand = LP_UP;
        else if (w_rise[2]) w_cand = LP_DOWN;
        else                w_cand_vld = 1'b0;
    end

    // on a tick the pending direction is what is about to be live
    assign w_ref    = bus.move_tick ? r_next : r_dir;
    assign w_accept = w_cand_vld && (w_cand != (w_ref ^ 2'b01));

    // edge history, pending update and commit on the game tick
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stable_d <= '0;
            r_pa       <= 1'b0;
            r_next     <= LP_RIGHT;
            r_dir      <= LP_RIGHT;
        end else begin
            r_stable_d <= r_stable;
            r_pa       <= w_accept;
            if (w_accept)      r_next <= w_cand;
            if (bus.move_tick) r_dir  <= r_next;
        end
    end

    assign bus.direction      = r_dir;
    assign bus.next_direction = r_next;
    assign bus.btn_state      = r_stable;
    assign bus.press_accepted = r_pa;

endmodule

// File: tb/tb_snake_dir_input.sv
// Cycle-table bench for snake_dir_input with a small
// expected-value queue, DEBOUNCE_CYCLES = 4.
module tb_snake_dir_input;

    localparam int DB = 4;
    localparam int CW = 3;

    localparam logic [3:0] Z  = 4'b0000;
    localparam logic [3:0] U  = 4'b1000;
    localparam logic [3:0] D  = 4'b0100;
    localparam logic [3:0] L  = 4'b0010;
    localparam logic [3:0] R  = 4'b0001;
    localparam logic [3:0] RU = 4'b1001;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    snake_dir_input_if bus ();

    snake_dir_input #(
        .DEBOUNCE_CYCLES (DB),
        .CNT_W           (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit         do_rst;
        logic [3:0] btn;
        bit         tick;
        logic [1:0] dir;
        logic [1:0] nxt;
        logic [3:0] st;
        bit         pa;
    } vec_t;

    vec_t       tbl [$];
    logic [8:0] sb  [$];
    int         n_run  = 0;
    int         n_fail = 0;

    function automatic void add(int n, int r, logic [3:0] b,
                                int t, int d, int nx,
                                logic [3:0] s, int p);
        vec_t v;
        for (int i = 0; i < n; i++) begin
            v.do_rst = (r != 0) && (i == 0);
            v.btn    = b;
            v.tick   = (t != 0);
            v.dir    = 2'(d);
            v.nxt    = 2'(nx);
            v.st     = s;
            v.pa     = (p != 0);
            tbl.push_back(v);
        end
    endfunction

    task automatic check(string nm, logic [8:0] exp);
        logic [8:0] act;
        act = {bus.direction, bus.next_direction,
               bus.btn_state, bus.press_accepted};
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: {dir,next,state,pa} got %b expected %b",
                     nm, act, exp);
        end
    endtask

    initial begin
        vec_t v;
        bus.btnu      = 1'b0;
        bus.btnd      = 1'b0;
        bus.btnl      = 1'b0;
        bus.btnr      = 1'b0;
        bus.move_tick = 1'b0;

        // 1: idle ticks
        add(1, 1, Z, 1, 1, 1, Z, 0);
        add(1, 0, Z, 0, 1, 1, Z, 0);
        add(1, 0, Z, 1, 1, 1, Z, 0);
        // 2: up press latency, commit, release
        add(5, 0, U, 0, 1, 1, Z, 0);
        add(1, 0, U, 0, 1, 1, U, 0);
        add(1, 0, U, 0, 1, 2, U, 1);
        add(1, 0, U, 0, 1, 2, U, 0);
        add(1, 0, U, 1, 2, 2, U, 0);
        add(5, 0, Z, 0, 2, 2, U, 0);
        add(1, 0, Z, 0, 2, 2, Z, 0);
        // 3: reversal rejected, then down accepted
        add(1, 1, L, 0, 1, 1, Z, 0);
        add(4, 0, L, 0, 1, 1, Z, 0);
        add(1, 0, L, 0, 1, 1, L, 0);
        add(1, 0, L, 0, 1, 1, L, 0);
        add(5, 0, Z, 0, 1, 1, L, 0);
        add(1, 0, Z, 0, 1, 1, Z, 0);
        add(5, 0, D, 0, 1, 1, Z, 0);
        add(1, 0, D, 0, 1, 1, D, 0);
        add(1, 0, D, 0, 1, 3, D, 1);
        add(5, 0, Z, 0, 1, 3, D, 0);
        add(1, 0, Z, 0, 1, 3, Z, 0);
        // 4: bounce ignored, steady 6-cycle press once
        add(1, 0, R, 0, 1, 3, Z, 0);
        add(1, 0, Z, 0, 1, 3, Z, 0);
        add(1, 0, R, 0, 1, 3, Z, 0);
        add(1, 0, Z, 0, 1, 3, Z, 0);
        add(4, 0, Z, 0, 1, 3, Z, 0);
        add(5, 0, R, 0, 1, 3, Z, 0);
        add(1, 0, R, 0, 1, 3, R, 0);
        add(1, 0, Z, 0, 1, 1, R, 1);
        add(4, 0, Z, 0, 1, 1, R, 0);
        add(1, 0, Z, 0, 1, 1, Z, 0);
        // 5: get to direction up
        add(5, 0, U, 0, 1, 1, Z, 0);
        add(1, 0, U, 0, 1, 1, U, 0);
        add(1, 0, U, 0, 1, 2, U, 1);
        add(5, 0, Z, 0, 1, 2, U, 0);
        add(1, 0, Z, 0, 1, 2, Z, 0);
        add(1, 0, Z, 1, 2, 2, Z, 0);
        // 5: right and up together, right wins
        add(5, 0, RU, 0, 2, 2, Z, 0);
        add(1, 0, RU, 0, 2, 2, RU, 0);
        add(1, 0, RU, 0, 2, 1, RU, 1);
        add(5, 0, Z, 0, 2, 1, RU, 0);
        add(1, 0, Z, 0, 2, 1, Z, 0);
        // 5: down lands on a tick, checked against next
        add(5, 0, D, 0, 2, 1, Z, 0);
        add(1, 0, D, 0, 2, 1, D, 0);
        add(1, 0, D, 1, 1, 3, D, 1);
        add(1, 0, D, 0, 1, 3, D, 0);
        add(5, 0, Z, 0, 1, 3, D, 0);
        add(1, 0, Z, 0, 1, 3, Z, 0);
        add(1, 0, Z, 1, 3, 3, Z, 0);
        // 6: reset mid-count, full latency afterwards
        add(3, 0, U, 0, 3, 3, Z, 0);
        add(1, 1, U, 0, 1, 1, Z, 0);
        add(4, 0, U, 0, 1, 1, Z, 0);
        add(1, 0, U, 0, 1, 1, U, 0);
        add(1, 0, U, 0, 1, 2, U, 1);
        add(1, 0, U, 0, 1, 2, U, 0);

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            {bus.btnu, bus.btnd, bus.btnl, bus.btnr} = v.btn;
            bus.move_tick = v.tick;
            if (v.do_rst) begin
                #2 rst = 1'b0;
                #1 check($sformatf("async_rst_row%0d", i),
                         9'b01_01_0000_0);
                @(negedge clk);
                rst = 1'b1;
            end
            sb.push_back({v.dir, v.nxt, v.st, v.pa});
            @(posedge clk);
            #1;
            check($sformatf("row%0d", i), sb.pop_front());
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
